// File: rtl/tmds_encoder.sv
// DVI TMDS encoder: expands 4-bit RGB to 8 bits and emits three 10-bit symbols per pixel_clock.
// Two-stage pipeline: transition minimisation, then DC balance / control-symbol insertion.
module tmds_encoder #(
  parameter bit SYNC_INV = 1'b0
) (
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic [3:0] R,
  input  logic [3:0] G,
  input  logic [3:0] B,
  input  logic       hsync_pulse,
  input  logic       vsync_pulse,
  input  logic       de,
  output logic [9:0] tmds_r,
  output logic [9:0] tmds_g,
  output logic [9:0] tmds_b
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  // Returns {next_cnt[5:0], symbol[9:0]} for one data symbol.
  function automatic logic [15:0] dc_balance(input logic [8:0] qm, input logic [3:0] n1,
                                             input logic [3:0] n0, input logic signed [5:0] cnt);
    logic signed [5:0] diff;
    logic signed [5:0] cnt_n;
    logic [9:0]        sym;
    diff = $signed({2'b00, n1}) - $signed({2'b00, n0});
    if ((cnt == 6'sd0) || (n1 == n0)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 6'sd0) && (n1 > n0)) || ((cnt < 6'sd0) && (n0 > n1))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? 6'sd0 : 6'sd2) + diff;
    end
    return {cnt_n, sym};
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  // Channel index: 0 = blue, 1 = green, 2 = red.
  logic [7:0]        d8      [3];
  logic [8:0]        qm_d    [3];
  logic [8:0]        qm_q    [3];
  logic [3:0]        n1_d    [3];
  logic [3:0]        n1_q    [3];
  logic [3:0]        n0_d    [3];
  logic [3:0]        n0_q    [3];
  logic              de_q;
  logic              hs_q;
  logic              vs_q;

  always_comb begin
    d8[0] = {B, B};
    d8[1] = {G, G};
    d8[2] = {R, R};
    for (int c = 0; c < 3; c++) begin
      qm_d[c] = tm_encode(d8[c]);
      n1_d[c] = ones8(qm_d[c][7:0]);
      n0_d[c] = 4'd8 - n1_d[c];
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        qm_q[c] <= 9'd0;
        n1_q[c] <= 4'd0;
        n0_q[c] <= 4'd0;
      end
    end else begin
      de_q <= de;
      hs_q <= hsync_pulse ^ SYNC_INV;
      vs_q <= vsync_pulse ^ SYNC_INV;
      for (int c = 0; c < 3; c++) begin
        qm_q[c] <= qm_d[c];
        n1_q[c] <= n1_d[c];
        n0_q[c] <= n0_d[c];
      end
    end
  end

  logic [9:0]        bal_sym [3];
  logic signed [5:0] bal_cnt [3];
  logic [1:0]        ctl     [3];
  logic [9:0]        sym_d   [3];
  logic [9:0]        sym_q   [3];
  logic signed [5:0] cnt_d   [3];
  logic signed [5:0] cnt_q   [3];

  // Sync rides only on blue; any control symbol zeroes the disparity so the next line starts balanced.
  always_comb begin
    ctl[0] = {vs_q, hs_q};
    ctl[1] = 2'b00;
    ctl[2] = 2'b00;
    for (int c = 0; c < 3; c++) begin
      {bal_cnt[c], bal_sym[c]} = dc_balance(qm_q[c], n1_q[c], n0_q[c], cnt_q[c]);
      sym_d[c] = de_q ? bal_sym[c] : ctrl_sym(ctl[c]);
      cnt_d[c] = de_q ? bal_cnt[c] : 6'sd0;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      for (int c = 0; c < 3; c++) begin
        sym_q[c] <= CTRL_00;
        cnt_q[c] <= 6'sd0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sym_q[c] <= sym_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign tmds_b = sym_q[0];
  assign tmds_g = sym_q[1];
  assign tmds_r = sym_q[2];

endmodule
